// File: rtl/edge_pulse_pkg.sv
// rtl/edge_pulse_pkg.sv - shared types and helpers for edge_pulse_array
package edge_pulse_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_e;

  typedef enum logic {
    CH_IDLE  = 1'b0,
    CH_PULSE = 1'b1
  } chan_state_e;

  function automatic logic edge_hit(input logic prev, input logic cur, input edge_mode_e mode);
    case (mode)
      EDGE_RISE: edge_hit = !prev && cur;
      EDGE_FALL: edge_hit = prev && !cur;
      EDGE_BOTH: edge_hit = prev != cur;
      default:   edge_hit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/edge_pulse_chan.sv
// rtl/edge_pulse_chan.sv - one channel: optional debounce (EDGE_PULSE_ARRAY_DEBOUNCE_EN),
// edge detect, pulse FSM and sticky missed flag
module edge_pulse_chan
  import edge_pulse_pkg::*;
#(
  parameter int PULSE_WIDTH     = 1,
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sig,
  input  logic [1:0] mode,
  input  logic       clr_missed,
  output logic       pulse,
  output logic       missed
);

  if (PULSE_WIDTH < 1 || PULSE_WIDTH > 255 || DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_param
    $error("edge_pulse_chan: PULSE_WIDTH and DEBOUNCE_CYCLES must be 1..255");
  end

  localparam logic [CNT_W-1:0] PW_LAST = CNT_W'(PULSE_WIDTH - 1);

  logic cur;

`ifdef EDGE_PULSE_ARRAY_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             filt;
  logic [CNT_W-1:0] db_cnt;

  // Any sample matching the filtered level restarts the run of differing samples.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      filt   <= 1'b0;
      db_cnt <= '0;
    end else if (sig == filt) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      filt   <= sig;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign cur = filt;
`else
  assign cur = sig;
`endif

  chan_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic             prev;
  logic             hit;

  assign hit = edge_hit(prev, cur, edge_mode_e'(mode));

  // A one-cycle pulse never occupies PULSE, so consecutive edges each get their own pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= CH_IDLE;
      cnt    <= '0;
      prev   <= 1'b0;
      pulse  <= 1'b0;
      missed <= 1'b0;
    end else begin
      prev   <= cur;
      missed <= (missed & ~clr_missed) | (hit & (state == CH_PULSE));
      case (state)
        CH_IDLE: begin
          pulse <= hit;
          if (hit && PULSE_WIDTH > 1) begin
            state <= CH_PULSE;
            cnt   <= PW_LAST;
          end
        end
        CH_PULSE: begin
          if (cnt == '0) begin
            state <= CH_IDLE;
            pulse <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/edge_pulse_array.sv
// rtl/edge_pulse_array.sv - array of independent edge-to-pulse channels
// (debounce filter enabled by EDGE_PULSE_ARRAY_DEBOUNCE_EN)
module edge_pulse_array
  import edge_pulse_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int PULSE_WIDTH     = 1,
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] sig_in,
  input  logic [1:0]          mode,
  input  logic                clr_missed,
  output logic [CHANNELS-1:0] pulse_out,
  output logic [CHANNELS-1:0] missed
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    edge_pulse_chan #(
      .PULSE_WIDTH     (PULSE_WIDTH),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .sig        (sig_in[i]),
      .mode       (mode),
      .clr_missed (clr_missed),
      .pulse      (pulse_out[i]),
      .missed     (missed[i])
    );
  end

endmodule
